// File: rtl/loader_write_bridge.sv
// Loader-to-SDRAM write bridge: buffers loader bytes and issues them on memory write slots.
// Optional running checksum of issued bytes enabled by LOADER_BRIDGE_CSUM_EN.
module loader_write_bridge #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     slot,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_din,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     idle,
    output logic [15:0]              csum
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [7:0]        fifo_data [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic              empty, full, pop, push, drop;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push = wr_valid && !reset && (!full || pop);
    assign drop = wr_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (slot && !empty) begin
                    pop       = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (slot) begin
                    if (!empty) pop = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= wr_addr;
            fifo_data[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr     <= rptr + 1'b1;
                mem_addr <= fifo_addr[rptr];
                mem_din  <= fifo_data[rptr];
            end
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    assign mem_we = (state == WRITE);
    assign idle   = empty && (state == IDLE);

`ifdef LOADER_BRIDGE_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset)    csum_q <= '0;
        else if (pop) csum_q <= csum_q + {8'd0, fifo_data[rptr]};
    end

    assign csum = csum_q;
`else
    assign csum = 16'd0;
`endif

endmodule
